// File: rtl/gp_dcache_if.sv
// Bundles for gp_dcache: the GP-Core data-port request bus and the
// word-wide backing-memory bus.
interface gp_dcache_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, be, addr, wdata, input rdata, ready);
    modport slave  (input req, we, be, addr, wdata, output rdata, ready);
endinterface

interface gp_dmem_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, we, be, addr, wdata, input rdata, ready);
    modport slave  (input req, we, be, addr, wdata, output rdata, ready);
endinterface

// File: rtl/gp_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// GP-Core data port and a word-wide backing memory; misses fill whole lines.
module gp_dcache #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       invalidate,
    gp_dcache_if.slave core,
    gp_dmem_if.master  mem
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int AW = IB + OB;
    localparam int TW = 30 - AW;
    localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [NUM_LINES-1:0] valid_r;
    logic [TW-1:0]        tag_r [NUM_LINES];
    logic [31:0]          data_r [2**AW];
    logic [OB-1:0]        cnt_r;
    logic [31:0]          rdata_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic [3:0]           mem_be_r;
    logic [31:0]          mem_addr_r;
    logic [31:0]          mem_wdata_r;

    logic [OB-1:0] off_s;
    logic [IB-1:0] idx_s;
    logic [TW-1:0] tag_s;
    logic          hit_s;
    logic          mem_done_s;
    logic          inv_s;
    logic          load_hit_s;
    logic          fill_start_s;
    logic          write_start_s;
    logic          fill_word_s;
    logic          fill_last_s;
    logic          write_done_s;
    logic          ready_s;
    logic          unused_addr_s;

    assign off_s         = core.addr[OB+1:2];
    assign idx_s         = core.addr[AW+1:OB+2];
    assign tag_s         = core.addr[31:AW+2];
    assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign mem_done_s    = mem_req_r && mem.ready;
    assign unused_addr_s = ^core.addr[1:0];

    // Next-state decode and the per-cycle action strobes
    always_comb begin
        state_nxt_s   = state_r;
        inv_s         = 1'b0;
        load_hit_s    = 1'b0;
        fill_start_s  = 1'b0;
        write_start_s = 1'b0;
        fill_word_s   = 1'b0;
        fill_last_s   = 1'b0;
        write_done_s  = 1'b0;
        ready_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (invalidate) begin
                    inv_s = 1'b1;
                end else if (core.req && core.we) begin
                    write_start_s = 1'b1;
                    state_nxt_s   = ST_WRITE;
                end else if (core.req && hit_s) begin
                    load_hit_s = 1'b1;
                    ready_s    = 1'b1;
                end else if (core.req) begin
                    fill_start_s = 1'b1;
                    state_nxt_s  = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem_done_s) begin
                    fill_word_s = 1'b1;
                    if (cnt_r == LAST_WORD) begin
                        fill_last_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (mem_done_s) begin
                    write_done_s = 1'b1;
                    ready_s      = core.req;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Tags, valid bits, load data and the registered backing-port request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= '0;
            cnt_r       <= '0;
            rdata_r     <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            // The line is invalid for the whole fill so an aborted fill leaves nothing half-valid
            if (inv_s) begin
                valid_r <= '0;
            end else if (fill_start_s) begin
                valid_r[idx_s] <= 1'b0;
            end else if (fill_last_s) begin
                valid_r[idx_s] <= 1'b1;
            end
            if (fill_last_s) begin
                tag_r[idx_s] <= tag_s;
            end
            if (load_hit_s) begin
                rdata_r <= data_r[{idx_s, off_s}];
            end
            if (fill_start_s) begin
                cnt_r      <= '0;
                mem_req_r  <= 1'b1;
                mem_we_r   <= 1'b0;
                mem_be_r   <= 4'b1111;
                mem_addr_r <= {core.addr[31:OB+2], {OB{1'b0}}, 2'b00};
            end else if (write_start_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b1;
                mem_be_r    <= core.be;
                mem_addr_r  <= {core.addr[31:2], 2'b00};
                mem_wdata_r <= core.wdata;
            end else if (fill_last_s || write_done_s) begin
                cnt_r     <= '0;
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
            end else if (fill_word_s) begin
                cnt_r      <= cnt_r + OB'(1);
                mem_addr_r <= {core.addr[31:OB+2], cnt_r + OB'(1), 2'b00};
            end
        end
    end

    // Line data store: fill words and write-through merges on store hits
    always_ff @(posedge clk) begin
        if (fill_word_s) begin
            data_r[{idx_s, cnt_r}] <= mem.rdata;
        end else if (write_done_s && hit_s) begin
            data_r[{idx_s, off_s}] <= merge_bytes(data_r[{idx_s, off_s}], core.wdata, core.be);
        end
    end

    assign core.rdata = rdata_r;
    assign core.ready = ready_s;
    assign mem.req    = mem_req_r;
    assign mem.we     = mem_we_r;
    assign mem.be     = mem_be_r;
    assign mem.addr   = mem_addr_r;
    assign mem.wdata  = mem_wdata_r;
endmodule

// File: tb/tb_gp_dcache.sv
// Randomized bench for gp_dcache: a latency-configurable backing memory plus a
// line-level reference model that predicts hits, latencies and load data.
module tb_gp_dcache;
    localparam int NUM_LINES  = 16;
    localparam int LINE_WORDS = 4;
    localparam int MEM_WORDS  = 4096;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic clk;
    logic rst_n;
    logic invalidate;

    gp_dcache_if core_if ();
    gp_dmem_if   mem_if ();

    gp_dcache #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .invalidate (invalidate),
        .core       (core_if),
        .mem        (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Backing memory and transaction logs
    logic [31:0] bmem [MEM_WORDS];
    bit          mem_init_done = 1'b0;
    int          mem_lat    = 1;
    bit          junk_ready = 1'b0;
    int          mem_wait;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  wr_be_log[$];

    always @(negedge clk) begin
        if (mem_if.req && (mem_wait >= mem_lat - 1)) begin
            mem_if.ready = 1'b1;
            mem_if.rdata = bmem[mem_if.addr[13:2]];
        end else if (mem_if.req) begin
            mem_if.ready = 1'b0;
            mem_if.rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end else begin
            mem_if.ready = junk_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_if.rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                bmem[i] <= 32'(i * 4) ^ 32'hDEAD_0000;
            end
            mem_init_done <= 1'b1;
        end else if (mem_if.req && mem_if.ready) begin
            mem_wait <= 0;
            if (mem_if.we) begin
                wr_addr_log.push_back(mem_if.addr);
                wr_data_log.push_back(mem_if.wdata);
                wr_be_log.push_back(mem_if.be);
                bmem[mem_if.addr[13:2]] <= apply_be(bmem[mem_if.addr[13:2]], mem_if.wdata, mem_if.be);
            end else begin
                rd_log.push_back(mem_if.addr);
            end
        end else if (mem_if.req) begin
            mem_wait <= mem_wait + 1;
        end else begin
            mem_wait <= 0;
        end
    end

    // Reference model: which line tag each set holds, and what memory contains
    logic [31:0] ref_mem [MEM_WORDS];
    bit          m_valid [NUM_LINES];
    int unsigned m_tag   [NUM_LINES];
    logic [31:0] exp_rdata;
    int          waited;

    task automatic model_clear();
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_be_log.delete();
    endtask

    task automatic do_reset();
        core_if.req = 1'b0;
        invalidate  = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        exp_rdata = 32'h0000_0000;
    endtask

    task automatic do_req(input bit we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit inv, output int cyc);
        @(negedge clk);
        core_if.req   = 1'b1;
        core_if.we    = we;
        core_if.be    = be;
        core_if.addr  = addr;
        core_if.wdata = wdata;
        invalidate    = inv;
        cyc = 0;
        forever begin
            #2;
            cyc++;
            check_eq("rdata_hold", core_if.rdata, exp_rdata);
            if (we && mem_if.req) begin
                check_eq("wr_we", 32'(mem_if.we), 32'd1);
                check_eq("wr_addr", mem_if.addr, {addr[31:2], 2'b00});
                check_eq("wr_be", 32'(mem_if.be), 32'(be));
                check_eq("wr_data", mem_if.wdata, wdata);
            end
            if (core_if.ready) break;
            if (cyc >= 200) begin
                check_eq("req_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(negedge clk);
            invalidate = 1'b0;
        end
        @(posedge clk);
        #1;
        core_if.req = 1'b0;
        invalidate  = 1'b0;
        #1;
        check_eq("idle_ready", 32'(core_if.ready), 32'd0);
    endtask

    task automatic run_load(input logic [31:0] addr, input bit inv);
        int unsigned line;
        int unsigned idx;
        int unsigned tag;
        int          cyc;
        int          exp_cyc;
        bit          hit;
        line = addr / LINE_BYTES;
        idx  = line % NUM_LINES;
        tag  = line / NUM_LINES;
        if (inv) model_clear();
        hit = m_valid[idx] && (m_tag[idx] == tag);
        clear_logs();
        do_req(1'b0, 4'b0000, addr, 32'h0000_0000, inv, cyc);
        exp_cyc = hit ? 1 : (LINE_WORDS * mem_lat + 2 + (inv ? 1 : 0));
        check_eq("load_cycles", 32'(cyc), 32'(exp_cyc));
        check_eq("load_reads", 32'(rd_log.size()), hit ? 32'd0 : 32'(LINE_WORDS));
        for (int i = 0; i < rd_log.size(); i++) begin
            check_eq("fill_addr", rd_log[i], 32'(line * LINE_BYTES + i * 4));
        end
        check_eq("load_writes", 32'(wr_addr_log.size()), 32'd0);
        exp_rdata = ref_mem[addr[13:2]];
        check_eq("load_data", core_if.rdata, exp_rdata);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        int cyc;
        clear_logs();
        do_req(1'b1, be, addr, wdata, 1'b0, cyc);
        check_eq("store_cycles", 32'(cyc), 32'(mem_lat + 1));
        check_eq("store_writes", 32'(wr_addr_log.size()), 32'd1);
        check_eq("store_reads", 32'(rd_log.size()), 32'd0);
        if (wr_addr_log.size() > 0) begin
            check_eq("store_log_addr", wr_addr_log[0], {addr[31:2], 2'b00});
            check_eq("store_log_be", 32'(wr_be_log[0]), 32'(be));
            check_eq("store_log_data", wr_data_log[0], wdata);
        end
        ref_mem[addr[13:2]] = apply_be(ref_mem[addr[13:2]], wdata, be);
        check_eq("store_rdata_hold", core_if.rdata, exp_rdata);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        rst_n         = 1'b0;
        invalidate    = 1'b0;
        core_if.req   = 1'b0;
        core_if.we    = 1'b0;
        core_if.be    = 4'b0000;
        core_if.addr  = 32'h0000_0000;
        core_if.wdata = 32'h0000_0000;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = 32'(i * 4) ^ 32'hDEAD_0000;
        end
        do_reset();
        #2;
        check_eq("rst_rdata", core_if.rdata, 32'h0000_0000);
        check_eq("rst_ready", 32'(core_if.ready), 32'd0);
        check_eq("rst_mem_req", 32'(mem_if.req), 32'd0);
        check_eq("rst_mem_we", 32'(mem_if.we), 32'd0);
        check_eq("rst_mem_be", 32'(mem_if.be), 32'd0);
        check_eq("rst_mem_addr", mem_if.addr, 32'h0000_0000);
        check_eq("rst_mem_wdata", mem_if.wdata, 32'h0000_0000);

        // Cold miss, hit, slow store hit, conflicts, no-write-allocate, invalidate
        mem_lat = 1;
        run_load(32'h0000_0100, 1'b0);
        run_load(32'h0000_0108, 1'b0);
        mem_lat = 3;
        run_store(32'h0000_0104, 4'b0011, 32'hAAAA_5555);
        mem_lat = 1;
        run_load(32'h0000_0104, 1'b0);
        check_eq("store_merge", core_if.rdata, 32'hDEAD_5555);
        run_load(32'h0000_0100, 1'b0);
        run_load(32'h0000_0200, 1'b0);
        run_load(32'h0000_0100, 1'b0);
        run_store(32'h0000_0300, 4'b1111, 32'h1234_5678);
        run_load(32'h0000_0300, 1'b0);
        run_load(32'h0000_0100, 1'b0);
        run_load(32'h0000_0100, 1'b1);

        // Reset in the middle of a fill
        do_reset();
        clear_logs();
        @(negedge clk);
        core_if.req  = 1'b1;
        core_if.we   = 1'b0;
        core_if.addr = 32'h0000_0100;
        waited = 0;
        while (rd_log.size() < 2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        #2;
        check_eq("midfill_words", 32'(rd_log.size()), 32'd2);
        check_eq("midfill_req_before", 32'(mem_if.req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midfill_req_drop", 32'(mem_if.req), 32'd0);
        check_eq("midfill_ready", 32'(core_if.ready), 32'd0);
        core_if.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        exp_rdata = 32'h0000_0000;
        run_load(32'h0000_0100, 1'b0);

        // Random mix against the reference model
        junk_ready = 1'b1;
        for (int n = 0; n < 250; n++) begin
            a = {20'h00000, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'b00};
            mem_lat = $urandom_range(1, 3);
            kind    = $urandom_range(0, 9);
            if (kind < 6) begin
                run_load(a, 1'b0);
            end else if (kind < 9) begin
                run_store(a, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                run_load(a, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
